// File: rtl/winograd_tile_buffer.sv
// Winograd tile buffer: turns a raster-order pixel stream into overlapping
// T x T tiles with stride T-K+1. The tiles are packed in the flattened layout
// that the F(2x2,3x3) PE reads on its inpData port.
module winograd_tile_buffer #(
  parameter int IMG_WIDTH        = 8,
  parameter int IMG_HEIGHT       = 8,
  parameter int INPUT_TILE_SIZE  = 4,
  parameter int KERNEL_SIZE      = 3,
  parameter int INPUT_DATA_WIDTH = 8,
  parameter int CHANNELS         = 3,
  localparam int T      = INPUT_TILE_SIZE,
  localparam int S      = INPUT_TILE_SIZE - KERNEL_SIZE + 1,
  localparam int W      = INPUT_DATA_WIDTH,
  localparam int C      = CHANNELS,
  localparam int PIX_W  = C * W,
  localparam int TILE_W = T * T * PIX_W,
  localparam int NTR    = (IMG_HEIGHT - T) / S + 1,
  localparam int NTC    = (IMG_WIDTH - T) / S + 1,
  localparam int TR_W   = $clog2(NTR) + 1,
  localparam int TC_W   = $clog2(NTC) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PIX_W-1:0]  in_pixel,
  output logic              tile_valid,
  input  logic              tile_ready,
  output logic [TILE_W-1:0] tile_data,
  output logic [TR_W-1:0]   tile_row,
  output logic [TC_W-1:0]   tile_col,
  output logic              frame_done
);

  localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int PR_W  = (T > 1) ? $clog2(T) : 1;

  // Geometry that cannot be tiled exactly is rejected at elaboration.
  if (IMG_WIDTH < T) begin : g_err_width
    $error("winograd_tile_buffer: IMG_WIDTH smaller than INPUT_TILE_SIZE");
  end
  if (IMG_HEIGHT < T) begin : g_err_height
    $error("winograd_tile_buffer: IMG_HEIGHT smaller than INPUT_TILE_SIZE");
  end
  if ((IMG_WIDTH - T) % S != 0) begin : g_err_wdiv
    $error("winograd_tile_buffer: IMG_WIDTH-T not divisible by stride");
  end
  if ((IMG_HEIGHT - T) % S != 0) begin : g_err_hdiv
    $error("winograd_tile_buffer: IMG_HEIGHT-T not divisible by stride");
  end

  typedef enum logic [0:0] {
    FILL = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t            state;
  logic [COL_W-1:0]  col_cnt;    // column of the next pixel to accept
  logic [ROW_W-1:0]  row_cnt;    // image row of the next pixel to accept
  logic [PR_W-1:0]   wr_phys;    // physical line-buffer row for row_cnt
  logic [PR_W-1:0]   base_phys;  // physical row holding tile row 0 of this band

  logic [PIX_W-1:0]  line_buf [T][IMG_WIDTH];

  logic              wr_en;
  logic              col_last;
  logic              row_is_last;
  logic [TC_W-1:0]   gather_tc;
  logic [TILE_W-1:0] gather;
  logic [PR_W-1:0]   wr_phys_next;
  logic [PR_W-1:0]   base_phys_next;

  assign wr_en       = in_valid && in_ready;
  assign col_last    = (col_cnt == COL_W'(IMG_WIDTH - 1));
  assign row_is_last = (int'(row_cnt) == S * int'(tile_row) + T - 1);
  // Tile to load next: column 0 when a band completes, else the following column.
  assign gather_tc   = (state == EMIT) ? tile_col + 1'b1 : '0;

  // Circular row pointers wrap at T.
  always_comb begin
    int nb;
    nb             = int'(base_phys) + S;
    if (nb >= T) nb = nb - T;
    base_phys_next = PR_W'(nb);
    wr_phys_next   = (wr_phys == PR_W'(T - 1)) ? '0 : wr_phys + 1'b1;
  end

  // Line buffer write port.
  // NOTE: the storage array has no reset; every entry is written before any tile
  // reads it, so clearing it would only cost a reset tree for no functional gain.
  always_ff @(posedge clk) begin
    if (wr_en) line_buf[wr_phys][col_cnt] <= in_pixel;
  end

  // Gather the next tile; the pixel being written this cycle is bypassed in so a
  // band's completing pixel is already visible in its first tile.
  always_comb begin
    int pr;
    int cc;
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise unassigned paths infer latches.
    gather = '0;
    pr     = 0;
    cc     = 0;
    for (int k = 0; k < C; k++) begin
      for (int i = 0; i < T; i++) begin
        for (int j = 0; j < T; j++) begin
          pr = int'(base_phys) + i;
          if (pr >= T) pr = pr - T;
          cc = S * int'(gather_tc) + j;
          if (wr_en && (int'(wr_phys) == pr) && (int'(col_cnt) == cc))
            gather[((T*i + j) + T*T*k)*W +: W] = in_pixel[k*W +: W];
          else
            gather[((T*i + j) + T*T*k)*W +: W] = line_buf[PR_W'(pr)][COL_W'(cc)][k*W +: W];
        end
      end
    end
  end

  // Control FSM: FILL accepts pixels until a band is complete, EMIT streams its tiles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= FILL;
      col_cnt    <= '0;
      row_cnt    <= '0;
      wr_phys    <= '0;
      base_phys  <= '0;
      tile_row   <= '0;
      tile_col   <= '0;
      in_ready   <= 1'b0;
      tile_valid <= 1'b0;
      tile_data  <= '0;
      frame_done <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every register
      // samples pre-edge values; a later assignment in this block overrides an
      // earlier default for the same register.
      frame_done <= 1'b0;
      case (state)
        FILL: begin
          in_ready <= 1'b1;
          if (wr_en) begin
            if (col_last) begin
              col_cnt <= '0;
              row_cnt <= row_cnt + 1'b1;
              wr_phys <= wr_phys_next;
              if (row_is_last) begin
                state      <= EMIT;
                in_ready   <= 1'b0;
                tile_valid <= 1'b1;
                tile_col   <= '0;
                tile_data  <= gather;
              end
            end else begin
              col_cnt <= col_cnt + 1'b1;
            end
          end
        end

        EMIT: begin
          if (tile_ready) begin
            if (tile_col != TC_W'(NTC - 1)) begin
              tile_col  <= tile_col + 1'b1;
              tile_data <= gather;
            end else begin
              state      <= FILL;
              tile_valid <= 1'b0;
              in_ready   <= 1'b1;
              tile_col   <= '0;
              if (tile_row != TR_W'(NTR - 1)) begin
                tile_row  <= tile_row + 1'b1;
                base_phys <= base_phys_next;
              end else begin
                frame_done <= 1'b1;
                tile_row   <= '0;
                row_cnt    <= '0;
                col_cnt    <= '0;
                wr_phys    <= '0;
                base_phys  <= '0;
              end
            end
          end
        end

        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: doc/winograd_tile_buffer.md
Name: winograd_tile_buffer

Overview:
- Upstream feeder for the Winograd F(2x2,3x3) processing element.
- Accepts a raster-order multi-channel pixel stream and buffers it in a 4-row circular line buffer.
- Emits overlapping INPUT_TILE_SIZE x INPUT_TILE_SIZE tiles with stride STRIDE = INPUT_TILE_SIZE-KERNEL_SIZE+1 (2 by default).
- Packs each tile in exactly the flattened format the PE's inpData port consumes.

Parameters:
- IMG_WIDTH, 8, pixels per row.
- IMG_HEIGHT, 8, rows per frame.
- INPUT_TILE_SIZE, 4, tile edge T.
- KERNEL_SIZE, 3, kernel edge; sets STRIDE = T-KERNEL_SIZE+1.
- INPUT_DATA_WIDTH, 8, bits per channel sample W.
- CHANNELS, 3, channels per pixel C.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  pixel present.
- in_ready  out  1  block accepts a pixel this cycle.
- in_pixel  in  C*W  channel k at bits [k*W +: W].
- tile_valid  out  1  tile_data holds a valid tile.
- tile_ready  in  1  consumer (PE) takes the tile.
- tile_data  out  T*T*W*C  element (i,j,k) at [((T*i+j)+T*T*k)*W +: W]; i = row in tile, j = column.
- tile_row  out  $clog2(NTR)+1  tile band index.
- tile_col  out  $clog2(NTC)+1  tile column index.
- frame_done  out  1  one-cycle pulse when the last tile of a frame is accepted.

Behaviour:
- Derived constants: NTR = (IMG_HEIGHT-T)/STRIDE+1; NTC = (IMG_WIDTH-T)/STRIDE+1.
- Elaboration error if IMG_WIDTH<T, IMG_HEIGHT<T, or either (dim-T) is not divisible by STRIDE.
- Reset (reset=0, async):
  - state=FILL; pixel column/row counters = 0; band = 0; tile_col = 0.
  - in_ready=0 while reset is asserted, 1 on the first cycle after release.
  - tile_valid=0, tile_data=0, tile_row=0, frame_done=0.
  - Line buffer contents are not cleared.
  - Reset mid-frame discards all progress; the next accepted pixel is (0,0).
- Line buffer: T rows x IMG_WIDTH entries x C*W bits. Image row r is stored in physical row r mod T.
- FILL state:
  - in_ready=1. A pixel is written on in_valid && in_ready.
  - Column counter wraps at IMG_WIDTH-1 and increments the row counter.
  - Band b needs rows 2b..2b+T-1. When the last pixel of row 2b+T-1 is accepted, go to EMIT next cycle with tile_col=0.
  - First band requires T full rows. Each later band requires STRIDE new rows; these overwrite the two oldest physical rows, which are no longer needed.
- EMIT state:
  - in_ready=0; in_valid is ignored.
  - tile_valid=1 from the cycle after the band's completing pixel, so latency from last pixel accepted to tile_valid = 1 cycle.
  - tile_data is registered and gathered from rows 2b..2b+T-1, columns 2*tile_col..2*tile_col+T-1. It is held stable while tile_valid && !tile_ready.
  - On tile_valid && tile_ready:
    - If tile_col < NTC-1: next tile is presented the following cycle (back-to-back, no bubble).
    - Else if band < NTR-1: band++, return to FILL, tile_valid=0.
    - Else (last tile of frame): frame_done=1 for exactly that following cycle. Return to FILL with all counters 0 for the next frame. Rows after the last band in frames with extra rows are not possible, given the divisibility check.
- Throughput:
  - First tile of a frame: after IMG_WIDTH*T pixels.
  - Each later band: after IMG_WIDTH*STRIDE pixels plus NTC emit cycles (when tile_ready=1).
- No arithmetic on data; samples pass through bit-exact and unsigned-agnostic.
- tile_ready while tile_valid=0 has no effect. in_valid=0 in FILL stalls without side effects.

Test Plan:
- Defaults. Drive 64 pixels with value(r,c,k) = 16r+c+64k; hold tile_ready=1.
  - Expect 9 tiles in order (0,0),(0,1),(0,2),(1,0)…(2,2).
  - Tile (1,2) element (i=3,j=0,k=2) = 16*5+4+128 = 212.
  - frame_done pulses once, the cycle after tile (2,2) is accepted.
- Latency check: tile_valid rises exactly 1 cycle after pixel (3,7) is accepted. in_ready is 0 for the 3 emit cycles, then 1.
- Backpressure: tile_ready=0 for 5 cycles on tile (0,1).
  - tile_data, tile_row and tile_col are stable throughout.
  - in_ready stays 0.
  - No tile is lost or duplicated.
- Input bubbles: in_valid toggles randomly at 50%. Tile contents must be identical to the first scenario.
- Async reset asserted mid-band 1, between clock edges.
  - tile_valid=0 and state=FILL immediately.
  - A fresh 64-pixel frame then yields the 9 correct tiles, with no stale data exposed.
- Back-to-back frames: send two frames with second-frame values +1. The second frame's tile (0,0) element (0,0,0) = 1, and two frame_done pulses occur in total.
